data_ram_ctrl: RTL and testbench

Responder end of the data-memory interface driven by the MEM stage. It accepts word-aligned read and byte-lane write requests, inserts a programmable number of wait states, and performs the access on an internal word-organised array. It returns read data with a one-cycle ready pulse, and drives a stall to the pipeline controller while a request is outstanding.

---
 rtl/data_ram_ctrl_pkg.sv | 17 +
 rtl/data_ram_array.sv | 29 ++
 rtl/data_ram_ctrl.sv | 112 +++++++++++
 tb/tb_data_ram_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/data_ram_ctrl_pkg.sv
// Shared bus widths and FSM encodings for the data-memory responder.
package data_ram_ctrl_pkg;

    localparam int DATA_BUS    = 32;
    localparam int ADDR_BUS    = 32;
    localparam int MEM_SEL_BUS = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // True when the byte address points beyond a 2**aw word array.
    function automatic logic addr_out_of_range(input logic [ADDR_BUS-1:0] addr, input int aw);
        return |(addr >> (aw + 2));
    endfunction

endpackage

// File: rtl/data_ram_array.sv
// Single-port word array with byte write enables and a registered read port.
module data_ram_array
    import data_ram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   en,
    input  logic [MEM_SEL_BUS-1:0] we,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [DATA_BUS-1:0]    wdata,
    output logic [DATA_BUS-1:0]    rdata
);

    logic [DATA_BUS-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (|we) begin
                for (int k = 0; k < MEM_SEL_BUS; k++) begin
                    if (we[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_ram_ctrl.sv
// Data-memory responder: wait-state FSM in front of data_ram_array.
// Optional DATA_RAM_RANGE_CHECK_EN adds ram_addr_err for out-of-range addresses.
module data_ram_ctrl
    import data_ram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ram_en,
    input  logic [MEM_SEL_BUS-1:0] ram_write_en,
    input  logic [ADDR_BUS-1:0]    ram_addr,
    input  logic [DATA_BUS-1:0]    ram_write_data,
    output logic [DATA_BUS-1:0]    ram_read_data,
    output logic                   ram_ready,
    output logic                   ram_stall
`ifdef DATA_RAM_RANGE_CHECK_EN
    ,
    output logic                   ram_addr_err
`endif
);

    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic [3:0]             cnt;
    logic [ADDR_WIDTH-1:0]  req_idx;
    logic [MEM_SEL_BUS-1:0] req_we;
    logic [DATA_BUS-1:0]    req_wdata;
    logic                   req_err;
    logic                   range_err;
    logic [DATA_BUS-1:0]    hold;
    logic [DATA_BUS-1:0]    arr_rdata;
    logic [DATA_BUS-1:0]    rd_word;
    logic [MEM_SEL_BUS-1:0] arr_we;
    logic                   acc;
    logic                   accept;
    logic                   unused_addr;

    assign unused_addr = ^{ram_addr[1:0], ram_addr[ADDR_BUS-1:ADDR_WIDTH+2]};

`ifdef DATA_RAM_RANGE_CHECK_EN
    assign range_err    = addr_out_of_range(ram_addr, ADDR_WIDTH);
    assign ram_addr_err = (state == ST_RESP) && req_err;
`else
    assign range_err = 1'b0;
`endif

    assign accept = (state == ST_IDLE) && ram_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // BUSY holds off while the pipeline keeps ram_en high; dropping it is a flush.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (ram_en) state_nxt = ST_BUSY;
            ST_BUSY: begin
                if (!ram_en)        state_nxt = ST_IDLE;
                else if (cnt == '0) state_nxt = ST_RESP;
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ram_ready = (state == ST_RESP);
        ram_stall = ram_en && (state != ST_RESP);
        acc       = (state == ST_BUSY) && ram_en && (cnt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             cnt <= '0;
        else if (accept)                        cnt <= 4'(WAIT_CYCLES);
        else if (state == ST_BUSY && cnt != '0) cnt <= cnt - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            req_idx   <= ram_addr[ADDR_WIDTH+1:2];
            req_we    <= ram_write_en;
            req_wdata <= ram_write_data;
            req_err   <= range_err;
        end
    end

    assign arr_we = req_err ? '0 : req_we;

    data_ram_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
        .clk   (clk),
        .en    (acc),
        .we    (arr_we),
        .addr  (req_idx),
        .wdata (req_wdata),
        .rdata (arr_rdata)
    );

    // The array read register has no reset, so the visible read word is
    // muxed during RESP and then parked in a resettable holding register.
    assign rd_word       = req_err ? '0 : arr_rdata;
    assign ram_read_data = (state == ST_RESP && req_we == '0) ? rd_word : hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              hold <= '0;
        else if (state == ST_RESP && req_we == '0) hold <= rd_word;
    end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Directed bench for data_ram_ctrl: WAIT_CYCLES=1 and WAIT_CYCLES=0 instances.
module tb_data_ram_ctrl;

    logic        clk;
    logic        rst_n;
    logic        en     [2];
    logic [3:0]  we     [2];
    logic [31:0] addr   [2];
    logic [31:0] wd     [2];
    logic [31:0] rdata  [2];
    logic        ready  [2];
    logic        stall  [2];
    logic        err    [2];

    int errors = 0;
    int checks = 0;

    data_ram_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .ram_en(en[0]), .ram_write_en(we[0]),
        .ram_addr(addr[0]), .ram_write_data(wd[0]), .ram_read_data(rdata[0]),
        .ram_ready(ready[0]), .ram_stall(stall[0])
`ifdef DATA_RAM_RANGE_CHECK_EN
        , .ram_addr_err(err[0])
`endif
    );

    data_ram_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .ram_en(en[1]), .ram_write_en(we[1]),
        .ram_addr(addr[1]), .ram_write_data(wd[1]), .ram_read_data(rdata[1]),
        .ram_ready(ready[1]), .ram_stall(stall[1])
`ifdef DATA_RAM_RANGE_CHECK_EN
        , .ram_addr_err(err[1])
`endif
    );

`ifndef DATA_RAM_RANGE_CHECK_EN
    assign err[0] = 1'b0;
    assign err[1] = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic issue(input int w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
        en[w] = 1'b1; we[w] = s; addr[w] = a; wd[w] = d;
    endtask

    // Counts cycles from the current one until ram_ready, and stall-high cycles.
    task automatic wait_ready(input int w, output int k, output int st,
                              output logic [31:0] rd, output logic er);
        k = 0; st = 0; rd = '0; er = 1'b0;
        #1;
        if (stall[w]) st++;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            k++;
            if (ready[w]) begin
                rd = rdata[w];
                er = err[w];
                if (stall[w]) st = st + 100;
                return;
            end
            if (stall[w]) st++;
        end
        check_val("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic txn(input int w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output int st, output logic [31:0] rd, output logic er);
        @(negedge clk);
        issue(w, s, a, d);
        wait_ready(w, lat, st, rd, er);
        en[w] = 1'b0;
        @(posedge clk);
    endtask

    int          lat, st, k1, k2, nready;
    logic [31:0] rd;
    logic        er;

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            en[i] = 1'b0; we[i] = '0; addr[i] = '0; wd[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_ready0", 32'(ready[0]), 32'd0);
        check_val("rst_rdata0", rdata[0], 32'h0);
        check_val("rst_rdata1", rdata[1], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);

        txn(0, 4'hF, 32'h0, 32'h01020304, lat, st, rd, er);
        txn(0, 4'hF, 32'h10, 32'hDEADBEEF, lat, st, rd, er);
        check_val("wr_latency", 32'(lat), 32'd3);
        check_val("wr_stall_cycles", 32'(st), 32'd3);
        check_val("wr_keeps_rdata", rd, 32'h0);
        txn(0, 4'h0, 32'h10, 32'h0, lat, st, rd, er);
        check_val("rd_latency", 32'(lat), 32'd3);
        check_val("rd_stall_cycles", 32'(st), 32'd3);
        check_val("rd_data", rd, 32'hDEADBEEF);
        check_val("rd_no_err", 32'(er), 32'd0);

        txn(0, 4'hF, 32'h20, 32'h11223344, lat, st, rd, er);
        txn(0, 4'b0010, 32'h20, 32'h0000AB00, lat, st, rd, er);
        txn(0, 4'h0, 32'h20, 32'h0, lat, st, rd, er);
        check_val("lane1_merge", rd, 32'h1122AB44);
        txn(0, 4'b1100, 32'h20, 32'hCDEF0000, lat, st, rd, er);
        txn(0, 4'h0, 32'h20, 32'h0, lat, st, rd, er);
        check_val("lane23_merge", rd, 32'hCDEFAB44);

        txn(0, 4'hF, 32'h30, 32'h0, lat, st, rd, er);
        @(negedge clk);
        issue(0, 4'hF, 32'h30, 32'hFFFFFFFF);
        @(posedge clk); #1;
        en[0] = 1'b0;
        nready = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (ready[0]) nready++;
        end
        check_val("flush_no_ready", 32'(nready), 32'd0);
        txn(0, 4'h0, 32'h30, 32'h0, lat, st, rd, er);
        check_val("flush_no_write", rd, 32'h0);

        txn(0, 4'h0, 32'h1010, 32'h0, lat, st, rd, er);
`ifdef DATA_RAM_RANGE_CHECK_EN
        check_val("oor_read_zero", rd, 32'h0);
        check_val("oor_read_err", 32'(er), 32'd1);
`else
        check_val("wrap_read", rd, 32'hDEADBEEF);
`endif

        txn(0, 4'hF, 32'h40, 32'h12345678, lat, st, rd, er);
        txn(0, 4'h0, 32'h40, 32'h0, lat, st, rd, er);
        check_val("pre_reset_read", rd, 32'h12345678);
        @(negedge clk);
        issue(0, 4'hF, 32'h40, 32'h99999999);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_ready", 32'(ready[0]), 32'd0);
        check_val("async_rst_rdata", rdata[0], 32'h0);
        en[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        txn(0, 4'h0, 32'h40, 32'h0, lat, st, rd, er);
        check_val("rst_drops_write", rd, 32'h12345678);
        check_val("post_rst_latency", 32'(lat), 32'd3);

        txn(1, 4'hF, 32'h0, 32'hA0A0A0A0, lat, st, rd, er);
        check_val("w0_wr_latency", 32'(lat), 32'd2);
        txn(1, 4'hF, 32'h4, 32'h0B0B0B0B, lat, st, rd, er);
        @(negedge clk);
        issue(1, 4'h0, 32'h0, 32'h0);
        wait_ready(1, k1, st, rd, er);
        check_val("b2b_first_lat", 32'(k1), 32'd2);
        check_val("b2b_first_data", rd, 32'hA0A0A0A0);
        issue(1, 4'h0, 32'h4, 32'h0);
        wait_ready(1, k2, st, rd, er);
        en[1] = 1'b0;
        check_val("b2b_second_lat", 32'(k1 + k2), 32'd5);
        check_val("b2b_second_data", rd, 32'h0B0B0B0B);
        @(posedge clk);

`ifdef DATA_RAM_RANGE_CHECK_EN
        txn(0, 4'hF, 32'h1000, 32'h5A5A5A5A, lat, st, rd, er);
        check_val("oor_write_err", 32'(er), 32'd1);
        check_val("oor_write_latency", 32'(lat), 32'd3);
        txn(0, 4'h0, 32'h0, 32'h0, lat, st, rd, er);
        check_val("oor_write_suppressed", rd, 32'h01020304);
        check_val("inrange_no_err", 32'(er), 32'd0);
        txn(0, 4'h0, 32'h1000, 32'h0, lat, st, rd, er);
        check_val("oor_read0_zero", rd, 32'h0);
        check_val("oor_read0_err", 32'(er), 32'd1);
`else
        txn(0, 4'h0, 32'h0, 32'h0, lat, st, rd, er);
        check_val("word0_read", rd, 32'h01020304);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
